// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg : shared types and helpers for the memory-access stage.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cpu_mem_pkg;

   localparam int BE_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DRAIN  = 2'd2
   } mem_state_e;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } mem_size_e;

   // Any size code other than byte/half is handled as a word access.
   function automatic logic misalign(input logic [1:0] size, input logic [1:0] addr_lo);
      logic r;
      case (size)
         SZ_BYTE: r = 1'b0;
         SZ_HALF: r = addr_lo[0];
         default: r = (addr_lo != 2'b00);
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_mem_align.sv
// ---------------------------------------------------------------------------
// cpu_mem_align : load lane extract/extend, store lane replicate and byte
// enables. Sub-word support is compiled in with MEM_SUBWORD_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_mem_align
   import cpu_mem_pkg::*;
(
   input  logic [1:0]      i_ld_size,
   input  logic            i_ld_unsigned,
   input  logic [1:0]      i_ld_addr_lo,
   input  logic [31:0]     i_rdata,
   output logic [31:0]     o_ld_data,
   input  logic [1:0]      i_st_size,
   input  logic [1:0]      i_st_addr_lo,
   input  logic [31:0]     i_st_data,
   output logic [31:0]     o_wdata,
   output logic [BE_W-1:0] o_be
);

`ifdef MEM_SUBWORD_EN
   logic [31:0] w_shifted;

   assign w_shifted = i_rdata >> {i_ld_addr_lo, 3'b000};

   always_comb begin
      o_ld_data = w_shifted;
      case (i_ld_size)
         SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_shifted[7]}},  w_shifted[7:0]};
         SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & w_shifted[15]}}, w_shifted[15:0]};
         default: ;
      endcase
   end

   always_comb begin
      o_wdata = i_st_data;
      o_be    = 4'b1111;
      case (i_st_size)
         SZ_BYTE: begin
            o_wdata = {4{i_st_data[7:0]}};
            o_be    = 4'b0001 << i_st_addr_lo;
         end
         SZ_HALF: begin
            o_wdata = {2{i_st_data[15:0]}};
            o_be    = 4'b0011 << i_st_addr_lo;
         end
         default: ;
      endcase
   end
`else
   logic w_unused_cfg;

   assign w_unused_cfg = ^{i_ld_size, i_ld_unsigned, i_ld_addr_lo, i_st_size, i_st_addr_lo};
   assign o_ld_data    = i_rdata;
   assign o_wdata      = i_st_data;
   assign o_be         = 4'b1111;
`endif

endmodule

`default_nettype wire

// File: rtl/cpu_mem_stage.sv
// ---------------------------------------------------------------------------
// cpu_mem_stage : memory-access pipeline stage (ALU pass-through, req/ack
// load/store, misalign and timeout errors). Optional macro MEM_SUBWORD_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cpu_mem_stage
   import cpu_mem_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int REG_W       = 5,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_mem_read,
   input  logic              in_mem_write,
   input  logic [1:0]        in_size,
   input  logic              in_unsigned,
   input  logic [DATA_W-1:0] in_alu_res,
   input  logic [DATA_W-1:0] in_st_data,
   input  logic              in_reg_write,
   input  logic [REG_W-1:0]  in_reg_dest,
   input  logic              flush,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [BE_W-1:0]   mem_be,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_reg_write,
   output logic [DATA_W-1:0] out_result,
   output logic [REG_W-1:0]  out_reg_dest,
   output logic              out_err
);

   localparam logic [1:0] ST_IDLE   = 2'(IDLE);
   localparam logic [1:0] ST_ACCESS = 2'(ACCESS);
   localparam logic [1:0] ST_DRAIN  = 2'(DRAIN);
   localparam int         CNT_W     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_TO = CNT_W'(TIMEOUT_CYC);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_flushed;
   logic             r_is_load;
   logic [1:0]       r_size;
   logic             r_unsigned;
   logic [1:0]       r_addr_lo;
   logic             r_reg_write;
   logic [REG_W-1:0] r_reg_dest;

   logic             w_accept;
   logic             w_is_mem;
   logic             w_is_store;
   logic [1:0]       w_size;
   logic             w_misalign;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_discard;
   logic [31:0]      w_ld_data;
   logic [31:0]      w_wdata;
   logic [BE_W-1:0]  w_be;

   assign in_ready   = (r_state == ST_IDLE) && (!out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_is_mem   = in_mem_read || in_mem_write;
   // A request with both read and write set is executed as a load.
   assign w_is_store = in_mem_write && !in_mem_read;
`ifdef MEM_SUBWORD_EN
   assign w_size     = in_size;
`else
   assign w_size     = 2'(SZ_WORD);
`endif
   assign w_misalign = misalign(w_size, in_alu_res[1:0]);
   assign w_cnt_nxt  = r_cnt + CNT_W'(1);
   assign w_discard  = r_flushed || flush;

   cpu_mem_align u_align (
      .i_ld_size     (r_size),
      .i_ld_unsigned (r_unsigned),
      .i_ld_addr_lo  (r_addr_lo),
      .i_rdata       (mem_rdata),
      .o_ld_data     (w_ld_data),
      .i_st_size     (in_size),
      .i_st_addr_lo  (in_alu_res[1:0]),
      .i_st_data     (in_st_data),
      .o_wdata       (w_wdata),
      .o_be          (w_be)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_flushed     <= 1'b0;
         r_is_load     <= 1'b0;
         r_size        <= 2'b00;
         r_unsigned    <= 1'b0;
         r_addr_lo     <= 2'b00;
         r_reg_write   <= 1'b0;
         r_reg_dest    <= '0;
         mem_req       <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         mem_be        <= '0;
         out_valid     <= 1'b0;
         out_reg_write <= 1'b0;
         out_result    <= '0;
         out_reg_dest  <= '0;
         out_err       <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (flush) begin
                  out_valid <= 1'b0;
               end else if (w_accept) begin
                  if (!w_is_mem || w_misalign) begin
                     out_valid     <= 1'b1;
                     out_err       <= w_is_mem;
                     out_reg_write <= in_reg_write && !w_is_mem;
                     out_result    <= in_alu_res;
                     out_reg_dest  <= in_reg_dest;
                  end else begin
                     r_state     <= ST_ACCESS;
                     r_cnt       <= '0;
                     r_flushed   <= 1'b0;
                     r_is_load   <= !w_is_store;
                     r_size      <= in_size;
                     r_unsigned  <= in_unsigned;
                     r_addr_lo   <= in_alu_res[1:0];
                     r_reg_write <= in_reg_write;
                     r_reg_dest  <= in_reg_dest;
                     mem_req     <= 1'b1;
                     mem_we      <= w_is_store;
                     mem_addr    <= {in_alu_res[ADDR_W-1:2], 2'b00};
                     mem_wdata   <= w_wdata;
                     mem_be      <= w_be;
                  end
               end
            end
            ST_ACCESS: begin
               // An ack in the same cycle as the timeout wins.
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  r_state <= ST_IDLE;
                  if (!w_discard) begin
                     out_valid     <= 1'b1;
                     out_err       <= 1'b0;
                     out_reg_write <= r_is_load && r_reg_write;
                     out_result    <= r_is_load ? w_ld_data : '0;
                     out_reg_dest  <= r_reg_dest;
                  end
               end else if (w_cnt_nxt == CNT_TO) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  r_cnt   <= w_cnt_nxt;
                  r_state <= ST_DRAIN;
                  if (!w_discard) begin
                     out_valid     <= 1'b1;
                     out_err       <= 1'b1;
                     out_reg_write <= 1'b0;
                     out_result    <= '0;
                     out_reg_dest  <= r_reg_dest;
                  end
               end else begin
                  r_cnt <= w_cnt_nxt;
                  if (flush)
                     r_flushed <= 1'b1;
               end
            end
            ST_DRAIN: begin
               if (mem_ack) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
